// File: rtl/legv8_mem_pkg.sv
// Shared definitions for the LEGv8 data-memory responder:
// FSM encoding, word geometry and response error code.
package legv8_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memStateT;

    localparam int         WORD_BYTES = 8;
    localparam logic [2:0] ALIGN_MASK = 3'b111;
    localparam logic       ERR_CODE   = 1'b1;

endpackage

// File: rtl/dmem_word_array.sv
// Word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_word_array #(
    parameter int DEPTH_WORDS = 128,
    parameter int DATA_WIDTH  = 64,
    parameter int IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
    input  logic                  clock,
    input  logic                  wrEn,
    input  logic [IDX_WIDTH-1:0]  wordIdx,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic [DATA_WIDTH-1:0] rdData
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wordIdx] <= wrData;
        end
    end

    assign rdData = mem[wordIdx];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory slave with fixed response latency,
// one outstanding request, and misalign/range error reporting.
module dmem_responder
    import legv8_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERROR
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LIMIT =
        ADDR_WIDTH'(DEPTH_WORDS * WORD_BYTES);

    memStateT              state;
    memStateT              nextState;
    logic [3:0]            count;
    logic                  accept;
    logic                  reqErr;
    logic                  wrEn;
    logic [IDXW-1:0]       wordIdx;
    logic [DATA_WIDTH-1:0] arrRdata;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic                  writeQ;
    logic                  errQ;

    assign wordIdx = REQ_ADDR[IDXW+2:3];
    // Any set bit at or above the storage range is an error; no wrap.
    assign reqErr  = (|(REQ_ADDR[2:0] & ALIGN_MASK)) | (REQ_ADDR >= LIMIT);
    assign accept  = REQ_VALID & REQ_READY;
    assign wrEn    = accept & REQ_WRITE & ~reqErr;

    dmem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_WIDTH (DATA_WIDTH)
    ) wordArray (
        .clock  (CLOCK),
        .wrEn   (wrEn),
        .wordIdx(wordIdx),
        .wrData (REQ_WDATA),
        .rdData (arrRdata)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (count <= 4'd1) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        RSP_RDATA = '0;
        RSP_ERROR = 1'b0;
        unique case (state)
            IDLE: REQ_READY = RESET;
            RESP: begin
                RSP_VALID = 1'b1;
                RSP_ERROR = errQ;
                RSP_RDATA = (writeQ | errQ) ? '0 : rdataQ;
            end
            default: ;
        endcase
    end

    // Read data is snapshotted at acceptance so later stores are invisible.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count  <= 4'd0;
            writeQ <= 1'b0;
            errQ   <= 1'b0;
            rdataQ <= '0;
        end else if (accept) begin
            count  <= 4'(LATENCY - 1);
            writeQ <= REQ_WRITE;
            errQ   <= reqErr ? ERR_CODE : ~ERR_CODE;
            rdataQ <= arrRdata;
        end else if (state == WAIT) begin
            count <= count - 4'd1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1 builds).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        reqValid;
    logic        reqWrite;
    logic        rspReady;
    logic [63:0] reqAddr;
    logic [63:0] reqWdata;
    logic        rdy2, vld2, err2;
    logic        rdy1, vld1, err1;
    logic [63:0] rd2, rd1;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(2)) u2 (
        .CLOCK(clk), .RESET(rst),
        .REQ_VALID(reqValid & ~sel), .REQ_READY(rdy2),
        .REQ_WRITE(reqWrite), .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
        .RSP_VALID(vld2), .RSP_READY(rspReady & ~sel),
        .RSP_RDATA(rd2), .RSP_ERROR(err2)
    );

    dmem_responder #(.LATENCY(1)) u1 (
        .CLOCK(clk), .RESET(rst),
        .REQ_VALID(reqValid & sel), .REQ_READY(rdy1),
        .REQ_WRITE(reqWrite), .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
        .RSP_VALID(vld1), .RSP_READY(rspReady & sel),
        .RSP_RDATA(rd1), .RSP_ERROR(err1)
    );

    logic        reqReadyS, rspValidS, rspErrorS;
    logic [63:0] rspRdataS;
    assign reqReadyS = sel ? rdy1 : rdy2;
    assign rspValidS = sel ? vld1 : vld2;
    assign rspErrorS = sel ? err1 : err2;
    assign rspRdataS = sel ? rd1 : rd2;

    int checks = 0;
    int errors = 0;
    int acc [2];

    // Reference storage: word contents plus "has been written" flag.
    logic [63:0] mdl [2][128];
    bit          kn  [2][128];

    always @(posedge clk) begin
        if (reqValid && !sel && rdy2) acc[0]++;
        if (reqValid && sel && rdy1) acc[1]++;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts at a negedge, ends at the negedge after the response handshake.
    task automatic doTxn(input bit w, input logic [63:0] a,
                         input logic [63:0] d, input int stall,
                         input bit hold, input bit early,
                         output logic actErr, output logic [63:0] actData);
        int n;
        int s;
        int idx;
        int accB;
        bit expErr;
        bit known;
        logic [63:0] expData;
        s = sel ? 1 : 0;
        expErr = (a[2:0] != 3'd0) || (a >= 64'd1024);
        idx = int'(a[9:3]);
        expData = 64'd0;
        known = 1'b1;
        if (!expErr && !w) begin
            expData = mdl[s][idx];
            known = kn[s][idx];
        end
        if (!expErr && w) begin
            mdl[s][idx] = d;
            kn[s][idx] = 1'b1;
        end
        accB = acc[s];
        reqValid = 1'b1;
        reqWrite = w;
        reqAddr = a;
        reqWdata = d;
        rspReady = early;
        n = 0;
        while (!reqReadyS && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 20), 64'd1);
        @(negedge clk);
        if (!hold) reqValid = 1'b0;
        chk("busy_ready", 64'(reqReadyS), 64'd0);
        n = 1;
        while (!rspValidS && n < 20) begin
            @(negedge clk);
            n++;
            chk("busy_ready", 64'(reqReadyS), 64'd0);
        end
        rspReady = 1'b0;
        chk("latency", 64'(n), 64'(sel ? 1 : 2));
        actErr = rspErrorS;
        actData = rspRdataS;
        chk("rsp_error", 64'(actErr), 64'(expErr));
        if (known) chk("rsp_rdata", actData, expData);
        repeat (stall) begin
            @(negedge clk);
            chk("stall_valid", 64'(rspValidS), 64'd1);
            chk("stall_data", rspRdataS, actData);
            chk("stall_ready", 64'(reqReadyS), 64'd0);
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        chk("rsp_drop", 64'(rspValidS), 64'd0);
        chk("idle_ready", 64'(reqReadyS), 64'd1);
        chk("one_accept", 64'(acc[s]), 64'(accB + 1));
    endtask

    typedef struct {
        bit          w;
        logic [63:0] a;
        logic [63:0] d;
        int          stall;
        bit          expErr;
        logic [63:0] expData;
    } vecT;

    vecT tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic        e;
        logic [63:0] dt;
        logic [63:0] a;
        int          n;
        bit          w;
        int          r;

        tbl[0] = '{1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 0, 1'b0, 64'd0};
        tbl[1] = '{1'b0, 64'h10, 64'd0, 0, 1'b0, 64'hDEAD_BEEF_0123_4567};
        tbl[2] = '{1'b1, 64'h13, 64'h1111, 0, 1'b1, 64'd0};
        tbl[3] = '{1'b0, 64'h10, 64'd0, 5, 1'b0, 64'hDEAD_BEEF_0123_4567};
        tbl[4] = '{1'b0, 64'h400, 64'd0, 0, 1'b1, 64'd0};
        tbl[5] = '{1'b1, 64'h3F8, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1'b0, 64'd0};
        tbl[6] = '{1'b0, 64'h3F8, 64'd0, 1, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0};
        tbl[7] = '{1'b0, 64'h1_0000_0010, 64'd0, 0, 1'b1, 64'd0};
        tbl[8] = '{1'b1, 64'h404, 64'h2222, 2, 1'b1, 64'd0};

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 128; i++) kn[s][i] = 1'b0;

        sel = 1'b0;
        rst = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr = '0;
        reqWdata = '0;
        rspReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(rdy2), 64'd0);
        chk("reset_valid", 64'(vld2), 64'd0);
        chk("reset_rdata", rd2, 64'd0);
        chk("reset_error", 64'(err2), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 64'(rdy2), 64'd1);

        for (int i = 0; i < 9; i++) begin
            doTxn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].stall,
                  1'b0, 1'(i % 2), e, dt);
            chk("vec_error", 64'(e), 64'(tbl[i].expErr));
            chk("vec_rdata", dt, tbl[i].expData);
        end

        // Held REQ_VALID across three back-to-back requests.
        doTxn(1'b1, 64'h20, 64'h0BAD_CAFE_0000_0001, 1, 1'b1, 1'b1, e, dt);
        doTxn(1'b0, 64'h20, 64'd0, 0, 1'b1, 1'b0, e, dt);
        chk("held_load20", dt, 64'h0BAD_CAFE_0000_0001);
        doTxn(1'b0, 64'h10, 64'd0, 2, 1'b1, 1'b1, e, dt);
        reqValid = 1'b0;
        chk("held_load10", dt, 64'hDEAD_BEEF_0123_4567);

        // Reset during WAIT: response must never appear.
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr = 64'h10;
        @(negedge clk);
        reqValid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_wait_valid", 64'(vld2), 64'd0);
        @(negedge clk);
        chk("rst_low_ready", 64'(rdy2), 64'd0);
        chk("rst_low_valid", 64'(vld2), 64'd0);
        rst = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (vld2) n++;
        end
        chk("no_ghost_rsp", 64'(n), 64'd0);
        chk("rst_release_ready", 64'(rdy2), 64'd1);
        doTxn(1'b0, 64'h10, 64'd0, 0, 1'b0, 1'b0, e, dt);
        chk("after_rst_load", dt, 64'hDEAD_BEEF_0123_4567);

        // Reset during RESP of a store: store stays committed.
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr = 64'h30;
        reqWdata = 64'h3030_3030_C0DE_0030;
        mdl[0][6] = 64'h3030_3030_C0DE_0030;
        kn[0][6] = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        chk("resp_before_rst", 64'(vld2), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_resp_valid", 64'(vld2), 64'd0);
        chk("rst_resp_rdata", rd2, 64'd0);
        chk("rst_resp_error", 64'(err2), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_resp_ready", 64'(rdy2), 64'd1);
        doTxn(1'b0, 64'h30, 64'd0, 0, 1'b0, 1'b0, e, dt);
        chk("committed_store", dt, 64'h3030_3030_C0DE_0030);

        // Randomized traffic on the LATENCY=2 build.
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            a = 64'($urandom_range(0, 127)) << 3;
            if (r == 0) a = a | 64'($urandom_range(1, 7));
            else if (r == 1) a = a + 64'd1024;
            else if (r == 2) a = a | (64'd1 << $urandom_range(10, 63));
            doTxn(w, a, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                  1'b0, 1'($urandom_range(0, 1)), e, dt);
        end

        // LATENCY=1 build: alternating store/load pairs.
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] v0;
            logic [63:0] v1;
            v0 = {$urandom, $urandom};
            v1 = {$urandom, $urandom};
            doTxn(1'b1, 64'h0, v0, 0, 1'b0, 1'b0, e, dt);
            doTxn(1'b0, 64'h0, 64'd0, 0, 1'b0, 1'b1, e, dt);
            chk("l1_load0", dt, v0);
            doTxn(1'b1, 64'h8, v1, 0, 1'b0, 1'b0, e, dt);
            doTxn(1'b0, 64'h8, 64'd0, 1, 1'b0, 1'b0, e, dt);
            chk("l1_load8", dt, v1);
        end
        for (int i = 0; i < 30; i++) begin
            a = 64'($urandom_range(0, 7)) << 3;
            if ($urandom_range(0, 5) == 0) a = a | 64'($urandom_range(1, 7));
            doTxn(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                  int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)),
                  e, dt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
